// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU read-side bus controller.
// Holds the controller state encoding and the default bus geometry.
package mem_bus_pkg;

    localparam int unsigned DefAddrW   = 32;
    localparam int unsigned DefDataW   = 32;
    localparam int unsigned DefTimeout = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2,
        StErr  = 2'd3
    } state_e;

endpackage

// File: rtl/timeout_cnt.sv
// Cycle counter with synchronous clear, enable and terminal-count flag.
// Saturates at TIMEOUT-1 so it can never wrap back to zero.
module timeout_cnt #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] Last = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != Last)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == Last);

endmodule

// File: rtl/mem_read_ctrl.sv
// Read-side bus controller: one outstanding read, variable-latency memory
// handshake, held read-data register and completion/timeout reporting.
module mem_read_ctrl
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic [DATA_W-1:0] cpu_data,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e state_q, state_d;
    logic   tc;

    logic              busy_q, done_q, err_q, rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_cnt (
        .clk(clk),
        .rst(rst),
        .clr(state_q != StReq),
        .en (state_q == StReq),
        .tc (tc)
    );

    // Ack is checked before the terminal count so a last-cycle ack still succeeds.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cpu_req) state_d = StReq;
            StReq: begin
                if (mem_ack) begin
                    state_d = StDone;
                end else if (tc) begin
                    state_d = StErr;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StDone) || (state_d == StErr);
            err_q   <= (state_d == StErr);
            rd_q    <= (state_d == StReq);
            if ((state_q == StIdle) && cpu_req) begin
                addr_q <= cpu_addr;
            end
            if ((state_q == StReq) && mem_ack) begin
                data_q <= mem_rdata;
            end
        end
    end

    assign cpu_busy = busy_q;
    assign cpu_done = done_q;
    assign cpu_err  = err_q;
    assign cpu_data = data_q;
    assign mem_rd   = rd_q;
    assign mem_addr = addr_q;

endmodule

// File: tb/tb_mem_read_ctrl.sv
// Directed self-checking bench for mem_read_ctrl with TIMEOUT=16.
module tb_mem_read_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_busy;
    logic        cpu_done;
    logic        cpu_err;
    logic [31:0] cpu_data;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int vectors;
    int miscompares;

    mem_read_ctrl #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_addr (cpu_addr),
        .cpu_busy (cpu_busy),
        .cpu_done (cpu_done),
        .cpu_err  (cpu_err),
        .cpu_data (cpu_data),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
        #2;
        vectors++;
        if ({cpu_busy, cpu_done, cpu_err, mem_rd} !== 4'b0000) begin
            $display("FAIL reset_ctrl got %b want 0000", {cpu_busy, cpu_done, cpu_err, mem_rd});
            miscompares++;
        end
        vectors++;
        if (mem_addr !== 32'h0 || cpu_data !== 32'h0) begin
            $display("FAIL reset_regs got addr=%h data=%h want 0/0", mem_addr, cpu_data);
            miscompares++;
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        cpu_req = 1'b1; cpu_addr = 32'h0000_0040;
        step();
        cpu_req = 1'b0;
        vectors++;
        if (mem_rd !== 1'b1 || mem_addr !== 32'h40 || cpu_busy !== 1'b1 || cpu_done !== 1'b0) begin
            $display("FAIL zw_req got rd=%b addr=%h busy=%b done=%b want 1/40/1/0",
                     mem_rd, mem_addr, cpu_busy, cpu_done);
            miscompares++;
        end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        vectors++;
        if (cpu_done !== 1'b1 || cpu_err !== 1'b0 || cpu_data !== 32'hDEAD_BEEF || mem_rd !== 1'b0) begin
            $display("FAIL zw_done got done=%b err=%b data=%h rd=%b want 1/0/deadbeef/0",
                     cpu_done, cpu_err, cpu_data, mem_rd);
            miscompares++;
        end
        step();
        vectors++;
        if (cpu_busy !== 1'b0 || cpu_done !== 1'b0) begin
            $display("FAIL zw_idle got busy=%b done=%b want 0/0", cpu_busy, cpu_done);
            miscompares++;
        end
    endtask

    task automatic test_wait_states();
        int bad;
        cpu_req = 1'b1; cpu_addr = 32'h0000_0080;
        step();
        cpu_req = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_rd !== 1'b1 || mem_addr !== 32'h80 || cpu_done !== 1'b0
                || cpu_data !== 32'hDEAD_BEEF) bad++;
            step();
        end
        vectors++;
        if (bad != 0 || mem_rd !== 1'b1) begin
            $display("FAIL ws_hold got %0d bad cycles rd=%b want 0 bad rd=1", bad, mem_rd);
            miscompares++;
        end
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0;
        vectors++;
        if (cpu_done !== 1'b1 || cpu_err !== 1'b0 || cpu_data !== 32'h1234_5678 || mem_rd !== 1'b0) begin
            $display("FAIL ws_done got done=%b err=%b data=%h rd=%b want 1/0/12345678/0",
                     cpu_done, cpu_err, cpu_data, mem_rd);
            miscompares++;
        end
        step();
        vectors++;
        if (cpu_done !== 1'b0 || cpu_busy !== 1'b0) begin
            $display("FAIL ws_single_pulse got done=%b busy=%b want 0/0", cpu_done, cpu_busy);
            miscompares++;
        end
    endtask

    task automatic test_timeout();
        int high;
        cpu_req = 1'b1; cpu_addr = 32'h0000_00C0;
        step();
        cpu_req = 1'b0;
        high = 0;
        for (int i = 0; i < 40; i++) begin
            if (mem_rd !== 1'b1) break;
            high++;
            step();
        end
        vectors++;
        if (high != 16) begin
            $display("FAIL to_rd_cycles got %0d want 16", high);
            miscompares++;
        end
        vectors++;
        if (cpu_done !== 1'b1 || cpu_err !== 1'b1 || cpu_data !== 32'h1234_5678) begin
            $display("FAIL to_err got done=%b err=%b data=%h want 1/1/12345678",
                     cpu_done, cpu_err, cpu_data);
            miscompares++;
        end
        step();
        vectors++;
        if (cpu_done !== 1'b0 || cpu_err !== 1'b0 || cpu_busy !== 1'b0) begin
            $display("FAIL to_clear got done=%b err=%b busy=%b want 0/0/0", cpu_done, cpu_err, cpu_busy);
            miscompares++;
        end
        // Ack on the sixteenth REQ edge coincides with expiry and must win.
        cpu_req = 1'b1; cpu_addr = 32'h0000_00C4;
        step();
        cpu_req = 1'b0;
        repeat (15) step();
        vectors++;
        if (mem_rd !== 1'b1 || cpu_done !== 1'b0) begin
            $display("FAIL to_edge_wait got rd=%b done=%b want 1/0", mem_rd, cpu_done);
            miscompares++;
        end
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_0016;
        step();
        mem_ack = 1'b0;
        vectors++;
        if (cpu_done !== 1'b1 || cpu_err !== 1'b0 || cpu_data !== 32'hA5A5_0016) begin
            $display("FAIL to_ack_wins got done=%b err=%b data=%h want 1/0/a5a50016",
                     cpu_done, cpu_err, cpu_data);
            miscompares++;
        end
        step();
    endtask

    task automatic test_back_to_back();
        int first_rise;
        int second_rise;
        int edge_no;
        first_rise = -1; second_rise = -1; edge_no = 0;
        cpu_req = 1'b1; cpu_addr = 32'h0000_0100;
        step(); edge_no++;
        if (mem_rd === 1'b1) first_rise = edge_no;
        vectors++;
        if (mem_addr !== 32'h100) begin
            $display("FAIL b2b_addr0 got %h want 00000100", mem_addr);
            miscompares++;
        end
        cpu_addr = 32'h0000_0104;
        mem_ack = 1'b1; mem_rdata = 32'h0000_1111;
        step(); edge_no++;
        mem_ack = 1'b0;
        vectors++;
        if (cpu_done !== 1'b1 || cpu_data !== 32'h0000_1111) begin
            $display("FAIL b2b_done0 got done=%b data=%h want 1/00001111", cpu_done, cpu_data);
            miscompares++;
        end
        step(); edge_no++;
        vectors++;
        if (mem_rd !== 1'b0 || cpu_busy !== 1'b0) begin
            $display("FAIL b2b_gap got rd=%b busy=%b want 0/0", mem_rd, cpu_busy);
            miscompares++;
        end
        step(); edge_no++;
        if (mem_rd === 1'b1) second_rise = edge_no;
        cpu_req = 1'b0;
        vectors++;
        if (first_rise != 1 || second_rise - first_rise != 3 || mem_addr !== 32'h104) begin
            $display("FAIL b2b_spacing got first=%0d second=%0d addr=%h want 1/4/00000104",
                     first_rise, second_rise, mem_addr);
            miscompares++;
        end
        mem_ack = 1'b1; mem_rdata = 32'h0000_2222;
        step();
        mem_ack = 1'b0;
        vectors++;
        if (cpu_done !== 1'b1 || cpu_data !== 32'h0000_2222) begin
            $display("FAIL b2b_done1 got done=%b data=%h want 1/00002222", cpu_done, cpu_data);
            miscompares++;
        end
        step();
        step();
        vectors++;
        if (mem_rd !== 1'b0 || cpu_busy !== 1'b0) begin
            $display("FAIL b2b_no_dup got rd=%b busy=%b want 0/0", mem_rd, cpu_busy);
            miscompares++;
        end
    endtask

    task automatic test_async_reset();
        cpu_req = 1'b1; cpu_addr = 32'h0000_0200;
        step();
        cpu_req = 1'b0;
        step();
        vectors++;
        if (mem_rd !== 1'b1 || cpu_busy !== 1'b1) begin
            $display("FAIL ar_in_req got rd=%b busy=%b want 1/1", mem_rd, cpu_busy);
            miscompares++;
        end
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if (mem_rd !== 1'b0 || cpu_busy !== 1'b0 || cpu_done !== 1'b0 || cpu_data !== 32'h0) begin
            $display("FAIL ar_immediate got rd=%b busy=%b done=%b data=%h want 0/0/0/0",
                     mem_rd, cpu_busy, cpu_done, cpu_data);
            miscompares++;
        end
        step();
        rst = 1'b0;
        step();
        vectors++;
        if (cpu_done !== 1'b0 || mem_addr !== 32'h0) begin
            $display("FAIL ar_no_done got done=%b addr=%h want 0/0", cpu_done, mem_addr);
            miscompares++;
        end
        cpu_req = 1'b1; cpu_addr = 32'h0000_0300;
        step();
        cpu_req = 1'b0;
        vectors++;
        if (mem_rd !== 1'b1 || mem_addr !== 32'h300) begin
            $display("FAIL ar_fresh_req got rd=%b addr=%h want 1/00000300", mem_rd, mem_addr);
            miscompares++;
        end
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_ack = 1'b0;
        vectors++;
        if (cpu_done !== 1'b1 || cpu_err !== 1'b0 || cpu_data !== 32'hCAFE_F00D) begin
            $display("FAIL ar_fresh_done got done=%b err=%b data=%h want 1/0/cafef00d",
                     cpu_done, cpu_err, cpu_data);
            miscompares++;
        end
        step();
    endtask

    task automatic test_spurious_ack();
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        step();
        mem_ack = 1'b0;
        vectors++;
        if (cpu_data !== 32'hCAFE_F00D || cpu_done !== 1'b0 || cpu_busy !== 1'b0 || mem_rd !== 1'b0) begin
            $display("FAIL spurious_ack got data=%h done=%b busy=%b rd=%b want cafef00d/0/0/0",
                     cpu_data, cpu_done, cpu_busy, mem_rd);
            miscompares++;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        test_spurious_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
